// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM state type and 2-input gate truth tables (bit index = {A,B})
package gate_test_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
endpackage

// File: rtl/settle_counter.sv
// settle_counter: 16-bit up-counter with synchronous clear and terminal-count flag at SETTLE_CYCLES-1
// Ports: clk, rst (async, active-high); en_i counts up; clr_i loads zero (wins over en_i); tc_o terminal count.
module settle_counter
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? 16'd0 : en_i ? cnt_q + 16'd1 : cnt_q;
    assign tc_o  = cnt_q == 16'(SETTLE_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps {A,B} through 00..11 into a 2-input gate, samples Y after a settle window, scores against TRUTH_TABLE
// Ports: clk, rst (async, active-high); start begins a run from IDLE/DONE; A/B registered stimulus; Y gate output;
//        busy while vectors are applied; done one-cycle end pulse; pass/err_count/fail_vec hold results until next run.
module gate_truth_checker
    import gate_test_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE   = TT_XNOR,
    parameter int unsigned SETTLE_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);
    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       tc;

    // counter restarts at every vector boundary and idles at zero outside DRIVE
    settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == DRIVE),
        .clr_i (state_q == DRIVE && tc),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            DRIVE: begin
                if (tc) begin
                    if (Y != TRUTH_TABLE[idx_q]) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                        pass_d  = err_d == 3'd0;
                    end
                end
            end
            default: begin
                state_d = start ? DRIVE : IDLE;
                if (start) begin
                    idx_d  = 2'd0;
                    err_d  = 3'd0;
                    fail_d = 4'd0;
                    pass_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    // idx wraps 11->00 on entry to DONE, so A/B return to zero there
    assign A         = idx_q[1];
    assign B         = idx_q[0];
    assign busy      = state_q == DRIVE;
    assign done      = state_q == DONE;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: directed, table-driven self-check of gate_truth_checker across three configurations
module tb_gate_truth_checker;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   sel = 0;
    int   mode = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic a4, b4, y4, busy4, done4, pass4;
    logic a1, b1, y1, busy1, done1, pass1;
    logic a100, b100, y100, busy100, done100, pass100;
    logic [2:0] err4, err1, err100;
    logic [3:0] fail4, fail1, fail100;

    // mode 0 = XNOR gate, 1 = XOR gate, 2 = tied high
    function automatic logic gate(input int m, input logic a, input logic b);
        return m == 0 ? ~(a ^ b) : m == 1 ? (a ^ b) : 1'b1;
    endfunction

    assign y4   = gate(mode, a4, b4);
    assign y1   = gate(2, a1, b1);
    assign y100 = gate(0, a100, b100);

    gate_truth_checker #(.TRUTH_TABLE(TT_XNOR), .SETTLE_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .A(a4), .B(b4), .Y(y4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_vec(fail4));
    gate_truth_checker #(.TRUTH_TABLE(TT_XNOR), .SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .A(a1), .B(b1), .Y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1));
    gate_truth_checker #(.TRUTH_TABLE(TT_AND), .SETTLE_CYCLES(100)) u100 (
        .clk(clk), .rst(rst), .start(start && sel == 2), .A(a100), .B(b100), .Y(y100),
        .busy(busy100), .done(done100), .pass(pass100), .err_count(err100), .fail_vec(fail100));

    logic       c_a, c_b, c_busy, c_done, c_pass;
    logic [2:0] c_err;
    logic [3:0] c_fail;
    assign c_a    = sel == 0 ? a4    : sel == 1 ? a1    : a100;
    assign c_b    = sel == 0 ? b4    : sel == 1 ? b1    : b100;
    assign c_busy = sel == 0 ? busy4 : sel == 1 ? busy1 : busy100;
    assign c_done = sel == 0 ? done4 : sel == 1 ? done1 : done100;
    assign c_pass = sel == 0 ? pass4 : sel == 1 ? pass1 : pass100;
    assign c_err  = sel == 0 ? err4  : sel == 1 ? err1  : err100;
    assign c_fail = sel == 0 ? fail4 : sel == 1 ? fail1 : fail100;

    typedef struct {
        int         dut;
        int         gmode;
        int         settle;
        logic [2:0] exp_err;
        logic [3:0] exp_fail;
        logic       exp_pass;
    } run_t;

    run_t runs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pulses start, follows the run cycle by cycle and checks the stimulus and results
    task automatic run_check(input run_t r);
        int n;
        sel  = r.dut;
        mode = r.gmode;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (c_done !== 1'b1 && n <= 4 * r.settle + 5) begin
            chk("busy_in_run", c_busy, 1);
            chk("ab_seq", {30'd0, c_a, c_b}, (n - 1) / r.settle);
            tick();
            n++;
        end
        chk("done_cycle", n, 4 * r.settle + 1);
        chk("busy_at_done", c_busy, 0);
        chk("ab_at_done", {c_a, c_b}, 0);
        chk("err_count", c_err, r.exp_err);
        chk("fail_vec", c_fail, r.exp_fail);
        chk("pass", c_pass, r.exp_pass);
        tick();
        chk("done_pulse_len", c_done, 0);
        chk("pass_hold", c_pass, r.exp_pass);
        chk("fail_hold", c_fail, r.exp_fail);
    endtask

    initial begin
        int n;
        runs[0] = '{0, 0, 4,   3'd0, 4'b0000, 1'b1};
        runs[1] = '{0, 1, 4,   3'd4, 4'b1111, 1'b0};
        runs[2] = '{1, 2, 1,   3'd2, 4'b0110, 1'b0};
        runs[3] = '{2, 0, 100, 3'd1, 4'b0001, 1'b0};

        #1;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk("rst_ab", {c_a, c_b}, 0);
            chk("rst_busy", c_busy, 0);
            chk("rst_done", c_done, 0);
            chk("rst_pass", c_pass, 0);
            chk("rst_err", c_err, 0);
            chk("rst_fail", c_fail, 0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_check(runs[i]);

        // reset during vector 10 of a failing run aborts without a done pulse
        sel = 0;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("pre_rst_ab", {c_a, c_b}, 2'b10);
        chk("pre_rst_err", c_err, 2);
        rst = 1'b1;
        #1;
        chk("abort_ab", {c_a, c_b}, 0);
        chk("abort_busy", c_busy, 0);
        chk("abort_err", c_err, 0);
        chk("abort_fail", c_fail, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (c_done !== 1'b0 || c_busy !== 1'b0) chk("no_done_after_abort", {c_done, c_busy}, 0);
            tick();
        end
        run_check(runs[0]);

        // mid-run start ignored; start held through DONE chains straight into a new run
        sel = 0;
        mode = 1;
        start = 1'b1;
        tick();
        for (n = 1; n <= 16; n++) begin
            start = n == 5 || n == 16;
            chk("chain_busy", c_busy, 1);
            chk("chain_no_done", c_done, 0);
            tick();
        end
        chk("chain_done", c_done, 1);
        chk("chain_err1", c_err, 4);
        chk("chain_fail1", c_fail, 4'b1111);
        chk("chain_pass1", c_pass, 0);
        tick();
        start = 1'b0;
        mode = 0;
        chk("chain_restart_busy", c_busy, 1);
        chk("chain_restart_ab", {c_a, c_b}, 0);
        chk("chain_clear_err", c_err, 0);
        chk("chain_clear_fail", c_fail, 0);
        chk("chain_clear_pass", c_pass, 0);
        n = 1;
        while (c_done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("chain_done_cycle", n, 17);
        chk("chain_err2", c_err, 0);
        chk("chain_pass2", c_pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
